button_event_arbiter: RTL

Debounces the 12 decoded button lines from the button-board receiver and turns stable transitions into press/release events. Events are queued in a small FIFO for the game/control logic. Simultaneous transitions are resolved by a round-robin arbiter, so no button starves. The block sits between the receiver's 12-bit output and the consumer FSM.

---
 rtl/button_event_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounces 12 button lines and queues the accepted transitions as events.
// Define BTN_RELEASE_EVT_EN to report releases too; by default only presses become events.
module button_event_arbiter #(
   parameter int TICK_DIV       = 1000,
   parameter int DEBOUNCE_TICKS = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] btn,
   output logic [11:0] held,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [3:0]  evt_id,
   output logic        evt_press,
   output logic        overflow,
   input  logic        clr_overflow
);
   localparam int NBTN = 12;
   localparam int TW   = $clog2(TICK_DIV);
   localparam int CW   = $clog2(DEBOUNCE_TICKS + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
`ifdef BTN_RELEASE_EVT_EN
   localparam int EW   = 5;
`else
   localparam int EW   = 4;
`endif

   logic [11:0]   btn_m, btn_s;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [CW-1:0] cnt [NBTN];
   logic [11:0]   accept, gen, pending, grant_mask, collide;
   logic [3:0]    rr_ptr, grant_idx;
   logic [4:0]    idx;
   logic          grant_valid;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [EW-1:0] wr_data, head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, push, pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_m <= '0;
         btn_s <= '0;
      end else begin
         btn_m <= btn;
         btn_s <= btn_m;
      end
   end

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + TW'(1);
   end

   always_comb begin
      accept = '0;
      for (int i = 0; i < NBTN; i++)
         accept[i] = (btn_s[i] != held[i]) && tick && (cnt[i] == CW'(DEBOUNCE_TICKS - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held <= '0;
         for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            if (btn_s[i] == held[i] || accept[i]) cnt[i] <= '0;
            else if (tick)                        cnt[i] <= cnt[i] + CW'(1);
         end
         held <= held ^ accept;
      end
   end

`ifdef BTN_RELEASE_EVT_EN
   logic [11:0] ptype;
   assign gen = accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptype <= '0;
      else       ptype <= (ptype & ~gen) | (gen & ~held);
   end

   assign wr_data = {ptype[grant_idx], grant_idx};
`else
   // Only 0->1 transitions generate events; releases just update held.
   assign gen     = accept & ~held;
   assign wr_data = grant_idx;
`endif

   // NOTE: blocking assignments in always_comb; every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = '0;
      for (int k = 0; k < NBTN; k++) begin
         idx = 5'(rr_ptr) + 5'(k);
         if (idx >= 5'(NBTN)) idx = idx - 5'(NBTN);
         if (!grant_valid && !full && pending[idx[3:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = idx[3:0];
         end
      end
   end

   assign grant_mask = grant_valid ? (12'd1 << grant_idx) : '0;
   // A collision granted in the same cycle loses nothing: the old event is pushed.
   assign collide    = gen & pending & ~grant_mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         rr_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         pending  <= (pending & ~grant_mask) | gen;
         overflow <= (overflow & ~clr_overflow) | (|collide);
         if (grant_valid) rr_ptr <= (grant_idx == 4'd11) ? 4'd0 : grant_idx + 4'd1;
      end
   end

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign push      = grant_valid;
   assign evt_valid = (count != '0);
   assign pop       = evt_valid && evt_ready;

   // NOTE: storage is not reset; outputs are gated by evt_valid so stale entries never show.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head   = mem[rd_ptr];
   assign evt_id = evt_valid ? head[3:0] : 4'd0;
`ifdef BTN_RELEASE_EVT_EN
   assign evt_press = evt_valid & head[4];
`else
   assign evt_press = 1'b1;
`endif

endmodule
